// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for the icache/dcache request channels.
// Optional transaction timeout enabled by defining MEMARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              merr
);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
    typedef enum logic {INSTR, DATA} chan_t;

    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    state_t            state, state_n;
    chan_t             last, last_n;
    logic [ADDR_W-1:0] laddr, laddr_n;
    logic [DATA_W-1:0] lstore, lstore_n;
    logic              lwen, lwen_n;
    logic              lren, lren_n;
    logic [DATA_W-1:0] iload_q, dload_q;
    logic              icomp, dcomp;
    logic              dreq, live, tmo_hit;
    chan_t             owner;

    assign dreq  = dREN | dWEN;
    assign owner = (state == DGRANT) ? DATA : INSTR;
    assign live  = (state == DGRANT) ? dreq : iREN;

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt;

    // Cleared while idle, so the first grant cycle always sees zero.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo_hit = (state != IDLE) &&
                     (ramstate != ACCESS) &&
                     (cnt == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        last_n   = last;
        laddr_n  = laddr;
        lstore_n = lstore;
        lwen_n   = lwen;
        lren_n   = lren;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        icomp    = 1'b0;
        dcomp    = 1'b0;
        merr     = 1'b0;
        unique case (state)
            IDLE: begin
                // On contention the channel that did not win last goes next.
                if (dreq && (!iREN || last == INSTR)) begin
                    state_n  = DGRANT;
                    laddr_n  = daddr;
                    lstore_n = dstore;
                    lwen_n   = dWEN;
                    lren_n   = dREN;
                end else if (iREN) begin
                    state_n  = IGRANT;
                    laddr_n  = iaddr;
                    lstore_n = '0;
                    lwen_n   = 1'b0;
                    lren_n   = 1'b1;
                end
            end
            DGRANT, IGRANT: begin
                ramaddr  = laddr;
                ramstore = lstore;
                ramWEN   = lwen;
                ramREN   = lren & ~lwen;
                if (!live) begin
                    state_n = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_n = IDLE;
                    last_n  = owner;
                    dcomp   = (owner == DATA);
                    icomp   = (owner == INSTR);
                end else if (ramstate == ERROR) begin
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    state_n = IDLE;
                    last_n  = owner;
                    merr    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign iwait = ~icomp;
    assign dwait = ~dcomp;
    assign iload = icomp ? ramload : iload_q;
    assign dload = dcomp ? ramload : dload_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            last    <= INSTR;
            laddr   <= '0;
            lstore  <= '0;
            lwen    <= 1'b0;
            lren    <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            laddr  <= laddr_n;
            lstore <= lstore_n;
            lwen   <= lwen_n;
            lren   <= lren_n;
            if (icomp) iload_q <= ramload;
            if (dcomp) dload_q <= ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus
// contention and (with MEMARB_TIMEOUT_EN) timeout sequences.
module tb_mem_arbiter;

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] E = 2'd3;

    localparam logic [31:0] IL = 32'h2001_0005;
    localparam logic [31:0] BF = 32'h0BAD_F00D;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] WS = 32'h1111_2222;

    typedef logic [132:0] obs_t;

    typedef struct {
        logic        rst_n;
        logic        iren;
        logic        dren;
        logic        dwen;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] rload;
        logic [1:0]  rstate;
        logic        iw;
        logic        dw;
        logic        ren;
        logic        wen;
        logic [31:0] raddr;
        logic [31:0] rstore;
        logic [31:0] il;
        logic [31:0] dl;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        merr;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .merr    (merr)
    );

    function automatic obs_t pk(
        logic iw, logic dw, logic ren, logic wen, logic me,
        logic [31:0] a, logic [31:0] s,
        logic [31:0] il, logic [31:0] dl
    );
        return {iw, dw, ren, wen, me, a, s, il, dl};
    endfunction

    function automatic obs_t actual();
        return pk(iwait, dwait, ramREN, ramWEN, merr,
                  ramaddr, ramstore, iload, dload);
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(
        logic r, logic i, logic dr, logic dw,
        logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
        logic [31:0] rl, logic [1:0] rs
    );
        @(posedge CLK);
        #1;
        nRST     = r;
        iREN     = i;
        dREN     = dr;
        dWEN     = dw;
        iaddr    = ia;
        daddr    = da;
        dstore   = ds;
        ramload  = rl;
        ramstate = rs;
        @(negedge CLK);
    endtask

    vec_t vt[31];

    initial begin
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = F;

        // reset held, then single read after 3 BUSY cycles
        vt[0]  = '{0,1,0,0,'h40,0,0,0,F, 1,1,0,0,0,0,0,0};
        vt[1]  = '{0,1,0,0,'h40,0,0,0,F, 1,1,0,0,0,0,0,0};
        vt[2]  = '{1,1,0,0,'h40,0,0,0,B, 1,1,0,0,0,0,0,0};
        vt[3]  = '{1,1,0,0,'h40,0,0,0,B, 1,1,1,0,'h40,0,0,0};
        vt[4]  = '{1,1,0,0,'h40,0,0,0,B, 1,1,1,0,'h40,0,0,0};
        vt[5]  = '{1,1,0,0,'h40,0,0,0,B, 1,1,1,0,'h40,0,0,0};
        vt[6]  = '{1,1,0,0,'h40,0,0,IL,A, 0,1,1,0,'h40,0,IL,0};
        vt[7]  = '{1,0,0,0,0,0,0,'h12345678,F, 1,1,0,0,0,0,IL,0};
        // write
        vt[8]  = '{1,0,0,1,0,'h100,DB,0,F, 1,1,0,0,0,0,IL,0};
        vt[9]  = '{1,0,0,1,0,'h100,DB,0,B, 1,1,0,1,'h100,DB,IL,0};
        vt[10] = '{1,0,0,1,0,'h100,DB,0,A, 1,0,0,1,'h100,DB,IL,0};
        vt[11] = '{1,0,0,0,0,0,0,0,F, 1,1,0,0,0,0,IL,0};
        // read withdrawn during BUSY
        vt[12] = '{1,0,1,0,0,'h200,0,0,F, 1,1,0,0,0,0,IL,0};
        vt[13] = '{1,0,1,0,0,'h200,0,0,B, 1,1,1,0,'h200,0,IL,0};
        vt[14] = '{1,0,0,0,0,'h200,0,0,B, 1,1,1,0,'h200,0,IL,0};
        vt[15] = '{1,0,0,0,0,0,0,'h55,A, 1,1,0,0,0,0,IL,0};
        // minimum-latency data read
        vt[16] = '{1,0,1,0,0,'h300,0,0,F, 1,1,0,0,0,0,IL,0};
        vt[17] = '{1,0,1,0,0,'h300,0,BF,A, 1,0,1,0,'h300,0,IL,BF};
        vt[18] = '{1,0,0,0,0,0,0,0,F, 1,1,0,0,0,0,IL,BF};
        // read+write together: write wins, then withdrawn
        vt[19] = '{1,0,1,1,0,'h400,WS,0,F, 1,1,0,0,0,0,IL,BF};
        vt[20] = '{1,0,1,1,0,'h400,WS,0,B, 1,1,0,1,'h400,WS,IL,BF};
        vt[21] = '{1,0,0,0,0,0,0,0,B, 1,1,0,1,'h400,WS,IL,BF};
        vt[22] = '{1,0,0,0,0,0,0,0,F, 1,1,0,0,0,0,IL,BF};
        // ERROR then retry
        vt[23] = '{1,1,0,0,'h80,0,0,0,F, 1,1,0,0,0,0,IL,BF};
        vt[24] = '{1,1,0,0,'h80,0,0,'h77,E, 1,1,1,0,'h80,0,IL,BF};
        vt[25] = '{1,1,0,0,'h80,0,0,0,F, 1,1,0,0,0,0,IL,BF};
        vt[26] = '{1,1,0,0,'h80,0,0,'h99,A, 0,1,1,0,'h80,0,'h99,BF};
        vt[27] = '{1,0,0,0,0,0,0,0,F, 1,1,0,0,0,0,'h99,BF};
        // reset mid-transaction
        vt[28] = '{1,1,0,0,'hC0,0,0,0,F, 1,1,0,0,0,0,'h99,BF};
        vt[29] = '{0,1,0,0,'hC0,0,0,0,B, 1,1,1,0,'hC0,0,'h99,BF};
        vt[30] = '{1,0,0,0,0,0,0,0,F, 1,1,0,0,0,0,0,0};

        for (int k = 0; k < 31; k++) begin
            drive(vt[k].rst_n, vt[k].iren, vt[k].dren, vt[k].dwen,
                  vt[k].iaddr, vt[k].daddr, vt[k].dstore,
                  vt[k].rload, vt[k].rstate);
            check($sformatf("vec%0d", k), actual(),
                  pk(vt[k].iw, vt[k].dw, vt[k].ren, vt[k].wen, 1'b0,
                     vt[k].raddr, vt[k].rstore, vt[k].il, vt[k].dl));
        end

        // contention: last grant is INSTR after reset, so data goes first
        begin
            logic [31:0] el, ed, rl;
            el = 32'h0;
            ed = 32'h0;
            for (int k = 0; k < 8; k++) begin
                rl = 32'hA000_0000 + 32'(k);
                drive(1, 1, 1, 0, 'h1000, 'h2000, 0, rl,
                      (k % 2 == 1) ? A : F);
                if (k % 2 == 0) begin
                    check($sformatf("cont_idle%0d", k), actual(),
                          pk(1, 1, 0, 0, 0, 0, 0, el, ed));
                end else if (((k >> 1) & 1) == 0) begin
                    ed = rl;
                    check($sformatf("cont_d%0d", k), actual(),
                          pk(1, 0, 1, 0, 0, 'h2000, 0, el, ed));
                end else begin
                    el = rl;
                    check($sformatf("cont_i%0d", k), actual(),
                          pk(0, 1, 1, 0, 0, 'h1000, 0, el, ed));
                end
            end

`ifdef MEMARB_TIMEOUT_EN
            drive(1, 1, 0, 0, 'h500, 0, 0, 0, B);
            check("tmo_idle", actual(), pk(1, 1, 0, 0, 0, 0, 0, el, ed));
            for (int t = 1; t <= 8; t++) begin
                drive(1, 1, 0, 0, 'h500, 0, 0, 0, B);
                check($sformatf("tmo_c%0d", t), actual(),
                      pk(1, 1, 1, 0, (t == 8), 'h500, 0, el, ed));
            end
            drive(1, 0, 0, 0, 0, 0, 0, 0, B);
            check("tmo_after", actual(), pk(1, 1, 0, 0, 0, 0, 0, el, ed));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
